// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantizes a serial sample stream and packs NUM_INPUTS channels per frame for the LUT network
module hgcal_input_packer #(
  parameter int NUM_INPUTS = 48,
  parameter int IN_WIDTH   = 10,
  parameter int QBITS      = 2,
  parameter int SHIFT      = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_WIDTH-1:0]         s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [NUM_INPUTS*QBITS-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        err_short,
  output logic                        err_long
);
  localparam int CW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int W = NUM_INPUTS * QBITS;
  localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);
  localparam logic [IN_WIDTH-1:0] QMAX = IN_WIDTH'(2 ** QBITS - 1);

  typedef enum logic {FILL, DISCARD} state_t;

  state_t state_q, state_d;
  logic [W-1:0] acc_q, acc_d, m_data_q, m_data_d, frame;
  logic [CW-1:0] cnt_q, cnt_d;
  logic m_valid_q, m_valid_d, err_short_q, err_short_d, err_long_q, err_long_d;
  logic [IN_WIDTH-1:0] shifted;
  logic [QBITS-1:0] q;
  logic beat, done;

  assign shifted = s_data >> SHIFT;
  assign q = shifted > QMAX ? QMAX[QBITS-1:0] : shifted[QBITS-1:0];
  assign s_ready = state_q == DISCARD || !m_valid_q || m_ready;
  assign beat = s_valid && s_ready;
  assign done = s_last || cnt_q == LAST;
  assign m_data = m_data_q;
  assign m_valid = m_valid_q;
  assign err_short = err_short_q;
  assign err_long = err_long_q;

  // Completed frame: stored channels, the incoming sample, zero padding above it
  always_comb begin
    frame = '0;
    for (int k = 0; k < NUM_INPUTS; k++)
      frame[k*QBITS +: QBITS] = k < int'(cnt_q) ? acc_q[k*QBITS +: QBITS] : k == int'(cnt_q) ? q : '0;
  end

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    m_data_d = m_data_q;
    m_valid_d = m_valid_q && !m_ready;
    err_short_d = 1'b0;
    err_long_d = 1'b0;
    if (beat && state_q == DISCARD) begin
      state_d = s_last ? FILL : DISCARD;
    end else if (beat && done) begin
      acc_d = '0;
      cnt_d = '0;
      m_data_d = frame;
      m_valid_d = 1'b1;
      err_short_d = s_last && cnt_q != LAST;
      err_long_d = !s_last && cnt_q == LAST;
      state_d = err_long_d ? DISCARD : FILL;
    end else if (beat) begin
      acc_d[cnt_q*QBITS +: QBITS] = q;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q <= '0;
      cnt_q <= '0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      m_data_q <= m_data_d;
      m_valid_q <= m_valid_d;
      err_short_q <= err_short_d;
      err_long_q <= err_long_d;
    end
  end
endmodule

// File: tb/tb_hgcal_input_packer.sv
// tb_hgcal_input_packer: directed and throttled-random checks of the 4-channel packer
module tb_hgcal_input_packer;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_ready;
  logic [NI*2-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_ready_dir = 1'b1;
  logic rand_mode = 1'b0;
  logic rnd_q = 1'b1;
  logic err_short, err_long;

  int n_chk = 0;
  int n_err = 0;
  int n_short = 0;
  int n_long = 0;
  logic [7:0] fr[$];

  always #5 clk = ~clk;

  assign m_ready = rand_mode ? rnd_q : m_ready_dir;

  always @(posedge clk) rnd_q <= $urandom_range(0, 3) != 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) fr.push_back(m_data);
    if (err_short) n_short++;
    if (err_long) n_long++;
  end

  hgcal_input_packer #(.NUM_INPUTS(NI), .IN_WIDTH(10), .QBITS(2), .SHIFT(6)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_short(err_short), .err_long(err_long)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; holds the beat until it is accepted
  task automatic send(input logic [9:0] d, input logic l, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 10'($urandom);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base, es, el, n;
    logic [7:0] exp_fr[$];
    int exp_short, exp_long;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_errs", {err_short, err_long}, 0);

    // 1: basic frame, one-cycle m_valid
    @(posedge clk);
    #1;
    send(0, 0, 0);
    send(100, 0, 0);
    send(150, 0, 0);
    send(1023, 1, 0);
    @(negedge clk);
    chk("t1_valid", m_valid, 1);
    chk("t1_data", m_data, 8'hE4);
    @(negedge clk);
    chk("t1_valid_drop", m_valid, 0);
    @(posedge clk);
    #1;

    // 2: output stall holds frame 1 and blocks frame 2
    base = fr.size();
    m_ready_dir = 1'b0;
    fork
      begin
        send(64, 0, 0);
        send(128, 0, 0);
        send(192, 0, 0);
        send(0, 1, 0);
        send(1023, 0, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        send(64, 1, 0);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          chk("t2_hold_valid", m_valid, 1);
          chk("t2_hold_data", m_data, 8'h39);
          chk("t2_stall_ready", s_ready, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_ready_dir = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("t2_count", fr.size() - base, 2);
    if (fr.size() >= base + 2) begin
      chk("t2_frame1", fr[base], 8'h39);
      chk("t2_frame2", fr[base+1], 8'h43);
    end
    @(posedge clk);
    #1;

    // 3: short frame
    base = fr.size();
    es = n_short;
    el = n_long;
    send(200, 0, 0);
    send(70, 1, 0);
    repeat (3) @(negedge clk);
    chk("t3_count", fr.size() - base, 1);
    if (fr.size() > base) chk("t3_frame", fr[base], 8'h07);
    chk("t3_err_short", n_short - es, 1);
    chk("t3_err_long", n_long - el, 0);
    @(posedge clk);
    #1;

    // 4: long frame, tail dropped, next frame restarts at channel 0
    base = fr.size();
    es = n_short;
    el = n_long;
    for (int i = 0; i < 4; i++) send(64, 0, 0);
    send(255, 0, 0);
    send(255, 1, 0);
    send(0, 0, 0);
    send(100, 0, 0);
    send(150, 0, 0);
    send(1023, 1, 0);
    repeat (3) @(negedge clk);
    chk("t4_count", fr.size() - base, 2);
    if (fr.size() >= base + 2) begin
      chk("t4_frame", fr[base], 8'h55);
      chk("t4_next", fr[base+1], 8'hE4);
    end
    chk("t4_err_long", n_long - el, 1);
    chk("t4_err_short", n_short - es, 0);
    @(posedge clk);
    #1;

    // 5: reset mid-frame and mid-handshake
    base = fr.size();
    send(100, 0, 0);
    send(200, 0, 0);
    pulse_rst();
    @(negedge clk);
    chk("t5_rst1_valid", m_valid, 0);
    chk("t5_rst1_ready", s_ready, 1);
    @(posedge clk);
    #1 m_ready_dir = 1'b0;
    for (int i = 0; i < 3; i++) send(1023, 0, 0);
    send(1023, 1, 0);
    @(negedge clk);
    chk("t5_pending_valid", m_valid, 1);
    pulse_rst();
    m_ready_dir = 1'b1;
    @(negedge clk);
    chk("t5_rst2_valid", m_valid, 0);
    chk("t5_rst2_data", m_data, 0);
    chk("t5_dropped", fr.size() - base, 0);
    @(posedge clk);
    #1;
    send(192, 0, 0);
    send(128, 0, 0);
    send(64, 0, 0);
    send(0, 1, 0);
    repeat (3) @(negedge clk);
    chk("t5_count", fr.size() - base, 1);
    if (fr.size() > base) chk("t5_frame", fr[base], 8'h1B);
    @(posedge clk);
    #1;

    // 6: random throttling against a frame-level model
    base = fr.size();
    es = n_short;
    el = n_long;
    exp_short = 0;
    exp_long = 0;
    rand_mode = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      logic [7:0] fv;
      len = $urandom_range(1, 6);
      fv = '0;
      for (int i = 0; i < len; i++) begin
        logic [9:0] d, sh;
        d = 10'($urandom_range(0, 1023));
        sh = d >> 6;
        if (i < 4) fv[i*2 +: 2] = sh > 3 ? 2'd3 : sh[1:0];
        send(d, i == len - 1, $urandom_range(0, 2));
      end
      exp_fr.push_back(fv);
      if (len < 4) exp_short++;
      if (len > 4) exp_long++;
    end
    rand_mode = 1'b0;
    n = 0;
    while (fr.size() < base + 1000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("t6_count", fr.size() - base, 1000);
    for (int i = 0; i < 1000 && base + i < fr.size(); i++) chk("t6_frame", fr[base+i], exp_fr[i]);
    chk("t6_err_short", n_short - es, exp_short);
    chk("t6_err_long", n_long - el, exp_long);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
